// File: rtl/arf_mp_pkg.sv
// Shared constants and helpers for the arf_mp multi-port architectural register file.
// Holds the default sizing, the hard-wired zero-register address and packed-port slicing helpers.
// Used by: arf_mp (top) and arf_mp_wr_arb (write-port arbitration).
package arf_mp_pkg;

  localparam int ARF_DATA_W_DEF   = 32;
  localparam int ARF_NUM_REGS_DEF = 32;
  localparam int ARF_NUM_RD_DEF   = 4;
  localparam int ARF_NUM_WR_DEF   = 2;

  // Register 0 is architecturally hard-wired to zero.
  localparam int ZERO_ADDR = 0;

  // Low bit of port 'port' inside a packed bus whose per-port field is 'width' bits.
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

  // Inclusive high bit of the same field.
  function automatic int port_hi(input int port, input int width);
    return port * width + width - 1;
  endfunction

endpackage

// File: rtl/arf_mp_wr_arb.sv
// Write-port resolver: maps the packed commit ports onto per-register write enables and data.
// Combinational (zero latency); the caller registers the collision flag.
// No backpressure: every enabled write is accepted; same-address conflicts go to the highest port.
// Ports:
//   wr_en_i/wr_addr_i/wr_data_i : packed commit write ports
//   reg_we_o/reg_wdata_o        : per-register write enable and winning data
//   collide_o                   : two or more enabled ports hit the same nonzero register
module arf_mp_wr_arb
  import arf_mp_pkg::*;
#(
  parameter int DATA_W   = ARF_DATA_W_DEF,
  parameter int NUM_REGS = ARF_NUM_REGS_DEF,
  parameter int NUM_WR   = ARF_NUM_WR_DEF,
  parameter int AW       = $clog2(ARF_NUM_REGS_DEF)
) (
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*AW-1:0]     wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  output logic [NUM_REGS-1:0]      reg_we_o,
  output logic [DATA_W-1:0]        reg_wdata_o [NUM_REGS],
  output logic                     collide_o
);

  // Ascending port scan: a later (higher) port overwrites an earlier match,
  // which gives the highest-numbered enabled port priority.
  always_comb begin
    reg_we_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      reg_wdata_o[r] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (r != ZERO_ADDR && wr_en_i[w] &&
            wr_addr_i[port_lo(w, AW) +: AW] == AW'(r)) begin
          reg_we_o[r]    = 1'b1;
          reg_wdata_o[r] = wr_data_i[port_lo(w, DATA_W) +: DATA_W];
        end
      end
    end
  end

  // Pairwise compare; writes to the zero register are dropped and never count.
  always_comb begin
    collide_o = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en_i[i] && wr_en_i[j] &&
            wr_addr_i[port_lo(i, AW) +: AW] == wr_addr_i[port_lo(j, AW) +: AW] &&
            wr_addr_i[port_lo(i, AW) +: AW] != AW'(ZERO_ADDR)) begin
          collide_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arf_mp.sv
// Multi-port architectural register file: NUM_RD registered read ports, NUM_WR commit write ports.
// Read latency one cycle; writes land at the sampling edge. Optional macro ARF_MP_BYPASS_EN
// forwards same-cycle write data to reads. No backpressure: all requests accepted every cycle.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   rd_en/rd_addr          : packed read requests; rd_data/rd_valid : registered results
//   wr_en/wr_addr/wr_data  : packed commit writes; wr_collide : registered same-address pulse
module arf_mp
  import arf_mp_pkg::*;
#(
  parameter int DATA_W   = ARF_DATA_W_DEF,
  parameter int NUM_REGS = ARF_NUM_REGS_DEF,
  parameter int NUM_RD   = ARF_NUM_RD_DEF,
  parameter int NUM_WR   = ARF_NUM_WR_DEF,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     wr_collide
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] reg_we;
  logic [DATA_W-1:0]   reg_wdata [NUM_REGS];
  logic                wr_collide_d;
  logic                wr_collide_q;

  arf_mp_wr_arb #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .NUM_WR  (NUM_WR),
    .AW      (AW)
  ) u_wr_arb (
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .reg_we_o   (reg_we),
    .reg_wdata_o(reg_wdata),
    .collide_o  (wr_collide_d)
  );

  // reg_we[0] is never raised by the arbiter, so entry 0 stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (reg_we[r]) regs_q[r] <= reg_wdata[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_collide_q <= 1'b0;
    else        wr_collide_q <= wr_collide_d;
  end
  assign wr_collide = wr_collide_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]     rd_addr_p;
    logic [DATA_W-1:0] rd_val_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    assign rd_addr_p = rd_addr[p*AW +: AW];

`ifdef ARF_MP_BYPASS_EN
    // Forward the winning commit data so the read observes this edge's write.
    assign rd_val_d = (rd_addr_p == AW'(ZERO_ADDR)) ? '0 :
                      reg_we[rd_addr_p]             ? reg_wdata[rd_addr_p] :
                                                      regs_q[rd_addr_p];
`else
    // Array contents before the edge; a same-cycle write shows up on the next read.
    assign rd_val_d = (rd_addr_p == AW'(ZERO_ADDR)) ? '0 : regs_q[rd_addr_p];
`endif

    // Idle ports keep their last data so the output never goes X; only valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (rd_en[p]) begin
        rd_data_q  <= rd_val_d;
        rd_valid_q <= 1'b1;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = rd_data_q;
    assign rd_valid[p]                 = rd_valid_q;
  end

endmodule

// File: tb/tb_arf_mp.sv
// Directed self-checking bench for arf_mp: default build plus a small and a wide parameter set.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants; bypass expectations follow ARF_MP_BYPASS_EN.
module tb_arf_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Default instance: 32x32, 4 read, 2 write
  logic [3:0]   rd_en   = '0;
  logic [19:0]  rd_addr = '0;
  logic [127:0] rd_data;
  logic [3:0]   rd_valid;
  logic [1:0]   wr_en   = '0;
  logic [9:0]   wr_addr = '0;
  logic [63:0]  wr_data = '0;
  logic         wr_collide;

  arf_mp dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_collide(wr_collide)
  );

  // Small instance: 8x16, 1 read, 1 write
  logic        s_rd_en   = 1'b0;
  logic [2:0]  s_rd_addr = '0;
  logic [15:0] s_rd_data;
  logic        s_rd_valid;
  logic        s_wr_en   = 1'b0;
  logic [2:0]  s_wr_addr = '0;
  logic [15:0] s_wr_data = '0;
  logic        s_wr_collide;

  arf_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(1), .NUM_WR(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_collide(s_wr_collide)
  );

  // Wide instance: 32x32, 8 read, 4 write
  logic [7:0]   w_rd_en   = '0;
  logic [39:0]  w_rd_addr = '0;
  logic [255:0] w_rd_data;
  logic [7:0]   w_rd_valid;
  logic [3:0]   w_wr_en   = '0;
  logic [19:0]  w_wr_addr = '0;
  logic [127:0] w_wr_data = '0;
  logic         w_wr_collide;

  arf_mp #(.NUM_RD(8), .NUM_WR(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .rd_en(w_rd_en), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_valid(w_rd_valid),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .wr_collide(w_wr_collide)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0;
    wr_en = '0;
  endtask

  task automatic wr(input int port, input logic [4:0] addr, input logic [31:0] data);
    wr_en[port] = 1'b1;
    wr_addr[port*5 +: 5] = addr;
    wr_data[port*32 +: 32] = data;
  endtask

  task automatic rd(input int port, input logic [4:0] addr);
    rd_en[port] = 1'b1;
    rd_addr[port*5 +: 5] = addr;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (rd_data !== 128'h0) begin n_bad++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    n_cmp++; if (rd_valid !== 4'h0) begin n_bad++; $display("FAIL reset_rd_valid got %h want 0", rd_valid); end
    n_cmp++; if (wr_collide !== 1'b0) begin n_bad++; $display("FAIL reset_collide got %b want 0", wr_collide); end
    rst_n = 1'b1;
    tick();
    wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    rd(0, 5'd5);
    wr(0, 5'd6, 32'h1);
    wr(1, 5'd6, 32'h2);
    tick();
    idle();
    n_cmp++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pre_reset_rd got %h want deadbeef", rd_data[31:0]); end
    n_cmp++; if (wr_collide !== 1'b1) begin n_bad++; $display("FAIL pre_reset_collide got %b want 1", wr_collide); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rd_data !== 128'h0) begin n_bad++; $display("FAIL async_rd_data got %h want 0", rd_data); end
    n_cmp++; if (rd_valid !== 4'h0) begin n_bad++; $display("FAIL async_rd_valid got %h want 0", rd_valid); end
    n_cmp++; if (wr_collide !== 1'b0) begin n_bad++; $display("FAIL async_collide got %b want 0", wr_collide); end
    rst_n = 1'b1;
    rd(0, 5'd5);
    tick();
    idle();
    n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL post_reset_r5 got %h want 0", rd_data[31:0]); end
    n_cmp++; if (rd_valid[0] !== 1'b1) begin n_bad++; $display("FAIL post_reset_valid got %b want 1", rd_valid[0]); end
  endtask

  task automatic test_basic();
    wr(0, 5'd3, 32'h12345678);
    tick();
    idle();
    rd(2, 5'd3);
    tick();
    idle();
    n_cmp++; if (rd_data[95:64] !== 32'h12345678) begin n_bad++; $display("FAIL basic_rd2 got %h want 12345678", rd_data[95:64]); end
    n_cmp++; if (rd_valid !== 4'b0100) begin n_bad++; $display("FAIL basic_valid got %b want 0100", rd_valid); end
    tick();
    n_cmp++; if (rd_valid !== 4'b0000) begin n_bad++; $display("FAIL basic_valid_drop got %b want 0000", rd_valid); end
  endtask

  task automatic test_collision();
    wr(0, 5'd7, 32'h1111);
    wr(1, 5'd7, 32'h2222);
    tick();
    idle();
    n_cmp++; if (wr_collide !== 1'b1) begin n_bad++; $display("FAIL collide_r7 got %b want 1", wr_collide); end
    rd(0, 5'd7);
    tick();
    idle();
    n_cmp++; if (wr_collide !== 1'b0) begin n_bad++; $display("FAIL collide_pulse got %b want 0", wr_collide); end
    n_cmp++; if (rd_data[31:0] !== 32'h2222) begin n_bad++; $display("FAIL collide_winner got %h want 2222", rd_data[31:0]); end
    wr(0, 5'd0, 32'hAAAA);
    wr(1, 5'd0, 32'hBBBB);
    rd(1, 5'd0);
    tick();
    idle();
    n_cmp++; if (wr_collide !== 1'b0) begin n_bad++; $display("FAIL collide_r0 got %b want 0", wr_collide); end
    n_cmp++; if (rd_data[63:32] !== 32'h0) begin n_bad++; $display("FAIL r0_same_cycle got %h want 0", rd_data[63:32]); end
    rd(1, 5'd0);
    tick();
    idle();
    n_cmp++; if (rd_data[63:32] !== 32'h0) begin n_bad++; $display("FAIL r0_after got %h want 0", rd_data[63:32]); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
`ifdef ARF_MP_BYPASS_EN
    exp_same = 32'hB;
`else
    exp_same = 32'hA;
`endif
    wr(0, 5'd9, 32'hA);
    tick();
    idle();
    wr(1, 5'd9, 32'hB);
    rd(3, 5'd9);
    tick();
    idle();
    n_cmp++; if (rd_data[127:96] !== exp_same) begin n_bad++; $display("FAIL bypass_same got %h want %h", rd_data[127:96], exp_same); end
    rd(3, 5'd9);
    tick();
    idle();
    n_cmp++; if (rd_data[127:96] !== 32'hB) begin n_bad++; $display("FAIL bypass_next got %h want b", rd_data[127:96]); end
  endtask

  task automatic test_hold();
    wr(0, 5'd4, 32'h55);
    tick();
    idle();
    rd(1, 5'd4);
    tick();
    idle();
    n_cmp++; if (rd_data[63:32] !== 32'h55) begin n_bad++; $display("FAIL hold_first got %h want 55", rd_data[63:32]); end
    wr(0, 5'd4, 32'h66);
    for (int c = 0; c < 3; c++) begin
      tick();
      idle();
      n_cmp++; if (rd_data[63:32] !== 32'h55) begin n_bad++; $display("FAIL hold_data%0d got %h want 55", c, rd_data[63:32]); end
      n_cmp++; if (rd_valid[1] !== 1'b0) begin n_bad++; $display("FAIL hold_valid%0d got %b want 0", c, rd_valid[1]); end
    end
    for (int p = 0; p < 4; p++) rd(p, 5'd4);
    tick();
    idle();
    n_cmp++; if (rd_data !== {4{32'h66}}) begin n_bad++; $display("FAIL all_ports_r4 got %h want 4x66", rd_data); end
    n_cmp++; if (rd_valid !== 4'hF) begin n_bad++; $display("FAIL all_ports_valid got %h want f", rd_valid); end
  endtask

  task automatic test_small_cfg();
    s_wr_en = 1'b1; s_wr_addr = 3'd7; s_wr_data = 16'hBEEF;
    tick();
    s_wr_addr = 3'd0; s_wr_data = 16'h1234;
    tick();
    s_wr_en = 1'b0;
    s_rd_en = 1'b1; s_rd_addr = 3'd7;
    tick();
    n_cmp++; if (s_rd_data !== 16'hBEEF) begin n_bad++; $display("FAIL small_r7 got %h want beef", s_rd_data); end
    s_rd_addr = 3'd0;
    tick();
    s_rd_en = 1'b0;
    n_cmp++; if (s_rd_data !== 16'h0) begin n_bad++; $display("FAIL small_r0 got %h want 0", s_rd_data); end
    n_cmp++; if (s_wr_collide !== 1'b0) begin n_bad++; $display("FAIL small_collide got %b want 0", s_wr_collide); end
  endtask

  task automatic test_wide_cfg();
    for (int w = 0; w < 4; w++) begin
      w_wr_en[w] = 1'b1;
      w_wr_addr[w*5 +: 5] = 5'd5;
      w_wr_data[w*32 +: 32] = 32'h10 * (w + 1);
    end
    tick();
    w_wr_en = '0;
    n_cmp++; if (w_wr_collide !== 1'b1) begin n_bad++; $display("FAIL wide_collide got %b want 1", w_wr_collide); end
    w_wr_en = 4'b1010;
    w_wr_addr = {5'd11, 5'd0, 5'd10, 5'd0};
    w_wr_data = {32'hC0DE, 32'h0, 32'hF00D, 32'h0};
    w_rd_en = 8'hFF;
    w_rd_addr = {5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5};
    tick();
    w_wr_en = '0;
    n_cmp++; if (w_rd_data !== {8{32'h40}}) begin n_bad++; $display("FAIL wide_winner got %h want 8x40", w_rd_data); end
    n_cmp++; if (w_wr_collide !== 1'b0) begin n_bad++; $display("FAIL wide_no_collide got %b want 0", w_wr_collide); end
    w_rd_en = 8'b0000_0011;
    w_rd_addr = {30'h0, 5'd11, 5'd10};
    tick();
    w_rd_en = '0;
    n_cmp++; if (w_rd_data[63:0] !== {32'hC0DE, 32'hF00D}) begin n_bad++; $display("FAIL wide_distinct got %h want c0de_f00d", w_rd_data[63:0]); end
    n_cmp++; if (w_rd_valid !== 8'b0000_0011) begin n_bad++; $display("FAIL wide_valid got %b want 00000011", w_rd_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_bypass();
    test_hold();
    test_small_cfg();
    test_wide_cfg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
